// File: rtl/lc3_obj_loader_if.sv
// Byte-stream and memory direct-access signals shared by the object loader
// and its host/memory side. The master modport is the loader itself.
interface lc3_obj_loader_if;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [15:0] address_in_direct;
    logic [15:0] data_in_direct;
    logic        clk_direct;
    logic [15:0] mem_out_direct;

    modport master (
        input  byte_in, byte_valid, mem_out_direct,
        output byte_ready, address_in_direct, data_in_direct, clk_direct
    );

    modport slave (
        output byte_in, byte_valid, mem_out_direct,
        input  byte_ready, address_in_direct, data_in_direct, clk_direct
    );
endinterface

// File: rtl/lc3_obj_loader.sv
// LC-3 object image loader: parses a big-endian origin/length/data byte
// stream, writes each word through the memory direct-access port, reads it
// back after READ_LAT cycles to verify it, and holds the CPU while loading.
module lc3_obj_loader #(
    parameter int READ_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    lc3_obj_loader_if.master   bus,
    output logic               cpu_hold,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [15:0]        words_loaded
);
    localparam logic [2:0] LAT = 3'(READ_LAT);

    typedef enum logic [3:0] {
        S_IDLE, S_ORG_HI, S_ORG_LO, S_LEN_HI, S_LEN_LO, S_DAT_HI,
        S_DAT_LO, S_WRITE, S_WAIT, S_CHECK, S_DONE, S_ERR
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_org;
    logic [15:0] r_len;
    logic [7:0]  r_hi;
    logic [15:0] r_addr;
    logic [15:0] r_data;
    logic [2:0]  r_wcnt;
    logic [15:0] r_words;

    logic        w_ready;
    logic        w_busy;
    logic        w_strobe;
    logic        w_done;
    logic        w_error;
    logic        w_xfer;
    logic        w_start_ok;
    logic        w_rd_ok;
    logic [15:0] w_len_full;
    logic [15:0] w_words_inc;

    assign w_xfer      = bus.byte_valid && w_ready;
    assign w_start_ok  = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
    assign w_rd_ok     = (bus.mem_out_direct == r_data);
    assign w_len_full  = {r_len[15:8], bus.byte_in};
    assign w_words_inc = r_words + 16'd1;

    // State register; reset forces IDLE and wins over a simultaneous start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: parse states advance only on an accepted byte.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: if (w_start_ok) w_next = S_ORG_HI;
            S_ORG_HI: if (w_xfer) w_next = S_ORG_LO;
            S_ORG_LO: if (w_xfer) w_next = S_LEN_HI;
            S_LEN_HI: if (w_xfer) w_next = S_LEN_LO;
            S_LEN_LO: if (w_xfer) w_next = (w_len_full == 16'd0) ? S_DONE : S_DAT_HI;
            S_DAT_HI: if (w_xfer) w_next = S_DAT_LO;
            S_DAT_LO: if (w_xfer) w_next = S_WRITE;
            S_WRITE:  w_next = S_WAIT;
            S_WAIT:   if (r_wcnt <= 3'd1) w_next = S_CHECK;
            S_CHECK: begin
                if (!w_rd_ok) begin
                    w_next = S_ERR;
                end else if (w_words_inc == r_len) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_DAT_HI;
                end
            end
            default:  w_next = S_IDLE;
        endcase
    end

    // Output decode: handshake, strobe and status are pure functions of state.
    always_comb begin
        w_ready  = 1'b0;
        w_busy   = 1'b1;
        w_strobe = 1'b0;
        w_done   = 1'b0;
        w_error  = 1'b0;
        case (r_state)
            S_IDLE: w_busy = 1'b0;
            S_DONE: begin
                w_busy = 1'b0;
                w_done = 1'b1;
            end
            S_ERR: begin
                w_busy  = 1'b0;
                w_error = 1'b1;
            end
            S_ORG_HI, S_ORG_LO, S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO: w_ready = 1'b1;
            S_WRITE: w_strobe = 1'b1;
            default: ;
        endcase
    end

    // Datapath: header capture, word assembly, latency counter, verify count.
    // The address/data registers are untouched between DAT_LO and CHECK so
    // the memory sees a stable word; on a failed verify the address is kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_org   <= '0;
            r_len   <= '0;
            r_hi    <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_wcnt  <= '0;
            r_words <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: if (w_start_ok) r_words <= '0;
                S_ORG_HI: if (w_xfer) r_org[15:8] <= bus.byte_in;
                S_ORG_LO: if (w_xfer) r_org[7:0]  <= bus.byte_in;
                S_LEN_HI: if (w_xfer) r_len[15:8] <= bus.byte_in;
                S_LEN_LO: begin
                    if (w_xfer) begin
                        r_len[7:0] <= bus.byte_in;
                        r_addr     <= r_org;
                    end
                end
                S_DAT_HI: if (w_xfer) r_hi <= bus.byte_in;
                S_DAT_LO: if (w_xfer) r_data <= {r_hi, bus.byte_in};
                S_WRITE:  r_wcnt <= LAT;
                S_WAIT:   r_wcnt <= r_wcnt - 3'd1;
                S_CHECK: begin
                    if (w_rd_ok) begin
                        r_words <= w_words_inc;
                        if (w_words_inc != r_len) r_addr <= r_addr + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.byte_ready        = w_ready;
    assign bus.address_in_direct = r_addr;
    assign bus.data_in_direct    = r_data;
    assign bus.clk_direct        = w_strobe;
    assign busy                  = w_busy;
    assign cpu_hold              = w_busy;
    assign done                  = w_done;
    assign error                 = w_error;
    assign words_loaded          = r_words;
endmodule
